// File: rtl/pc_display_scanner.sv
// Scans a captured program-counter value across common-anode digits, one nibble
// per refresh slot, applying new values only at frame boundaries.
module pc_display_scanner #(
  parameter int DIGITS        = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [4*DIGITS-1:0]   Value,
  input  logic                  Load,
  input  logic                  Enable,
  output logic [3:0]            Number,
  output logic                  Button,
  output logic [DIGITS-1:0]     Anode,
  output logic                  Valid
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [DW-1:0]         div_q, div_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   pend_q, pend_d;
  logic                  pend_flag_q, pend_flag_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic                  valid_q, valid_d;
  logic [3:0]            number_q, number_d;
  logic                  button_q, button_d;
  logic [DIGITS-1:0]     anode_q, anode_d;

  logic tc;
  logic fb;
  logic upper_nz;
  logic blank;

  always_comb begin
    tc = (div_q == DIV_LAST);
    fb = tc && (idx_q == IDX_LAST);

    div_d = tc ? '0 : div_q + DW'(1);
    idx_d = idx_q;
    if (tc) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    shadow_d    = shadow_q;
    valid_d     = valid_q;
    // A Load on the boundary cycle wins over any older pending value.
    if (fb) begin
      if (Load) begin
        shadow_d    = Value;
        pend_flag_d = 1'b0;
        valid_d     = 1'b1;
      end else if (pend_flag_q) begin
        shadow_d    = pend_q;
        pend_flag_d = 1'b0;
        valid_d     = 1'b1;
      end
    end else if (Load) begin
      pend_d      = Value;
      pend_flag_d = 1'b1;
    end

    // Blank when this digit and every more-significant digit are zero.
    upper_nz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(idx_q) && shadow_q[4*i +: 4] != 4'h0) upper_nz = 1'b1;
    end
    blank = (BLANK_LEADING != 0) && (idx_q != '0) && !upper_nz;

    number_d = 4'h0;
    anode_d  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) number_d = shadow_q[4*i +: 4];
      anode_d[i] = !(Enable && (idx_q == IW'(i)));
    end
    button_d = Enable && valid_q && !blank;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q       <= '0;
      idx_q       <= '0;
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
      shadow_q    <= '0;
      valid_q     <= 1'b0;
      number_q    <= 4'h0;
      button_q    <= 1'b0;
      anode_q     <= '1;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      shadow_q    <= shadow_d;
      valid_q     <= valid_d;
      number_q    <= number_d;
      button_q    <= button_d;
      anode_q     <= anode_d;
    end
  end

  assign Number = number_q;
  assign Button = button_q;
  assign Anode  = anode_q;
  assign Valid  = valid_q;

endmodule

// File: tb/tb_pc_display_scanner.sv
// Scoreboard bench for pc_display_scanner: a frame-level reference model pushes
// expected outputs per cycle; a monitor compares after each rising edge.
module tb_pc_display_scanner;
  localparam int DIGITS = 4;
  localparam int RDIV   = 4;
  localparam int FRAME  = RDIV * DIGITS;
  localparam int W      = 10;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] Value = '0;
  logic        Load = 1'b0;
  logic        Enable = 1'b0;
  logic [3:0]  Number;
  logic        Button;
  logic [3:0]  Anode;
  logic        Valid;

  pc_display_scanner #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV), .BLANK_LEADING(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Value(Value), .Load(Load), .Enable(Enable),
    .Number(Number), .Button(Button), .Anode(Anode), .Valid(Valid)
  );

  always #5 Clk = ~Clk;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cycles since reset, the value on show and the waiting value.
  int m_k;
  bit m_pend;
  int m_pend_val;
  int m_shown;
  bit m_valid;

  function automatic void model_reset();
    m_k = 0; m_pend = 0; m_pend_val = 0; m_shown = 0; m_valid = 0;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got valid=%b anode=%b button=%b number=%h, expected valid=%b anode=%b button=%b number=%h",
               name, $time, act[9], act[8:5], act[4], act[3:0], exp[9], exp[8:5], exp[4], exp[3:0]);
    end
  endtask

  // Called at a falling edge: drives inputs for the next rising edge and
  // records what the outputs must be after that edge.
  task automatic step(input bit ld, input logic [15:0] val, input bit en);
    int idx;
    bit fb;
    bit blank;
    logic [3:0] an;
    logic [3:0] num;
    bit btn;
    Load = ld; Value = val; Enable = en;
    idx   = (m_k / RDIV) % DIGITS;
    fb    = (m_k % FRAME) == FRAME - 1;
    blank = (idx > 0) && ((m_shown >> (4 * idx)) == 0);
    an    = en ? (4'hF ^ (4'(1) << idx)) : 4'hF;
    num   = 4'((m_shown >> (4 * idx)) & 15);
    btn   = en && m_valid && !blank;
    if (fb) begin
      if (ld) begin m_shown = int'(val); m_valid = 1; m_pend = 0; end
      else if (m_pend) begin m_shown = m_pend_val; m_valid = 1; m_pend = 0; end
    end else if (ld) begin
      m_pend = 1; m_pend_val = int'(val);
    end
    m_k++;
    exp_q.push_back({m_valid, an, btn, num});
    @(negedge Clk);
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, en);
  endtask

  // Starts and ends at a falling edge; asserts reset partway through a slot.
  task automatic pulse_reset();
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    Load = 1'b0;
    exp_q.delete();
    #1;
    check("reset_async", {Valid, Anode, Button, Number}, {1'b0, 4'hF, 1'b0, 4'h0});
    @(negedge Clk);
    check("reset_held", {Valid, Anode, Button, Number}, {1'b0, 4'hF, 1'b0, 4'h0});
    @(negedge Clk);
    model_reset();
    Reset_n = 1'b1;
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scan", {Valid, Anode, Button, Number}, e);
      end
    end
  end

  initial begin : driver
    logic [15:0] v;
    model_reset();
    repeat (3) @(negedge Clk);
    check("reset_init", {Valid, Anode, Button, Number}, {1'b0, 4'hF, 1'b0, 4'h0});
    Reset_n = 1'b1;

    idle(40, 1'b1);
    idle(6, 1'b1);
    step(1'b1, 16'h12AB, 1'b1);
    idle(2 * FRAME, 1'b1);

    step(1'b1, 16'h00F0, 1'b1);
    idle(2 * FRAME, 1'b1);
    step(1'b1, 16'h0000, 1'b1);
    idle(2 * FRAME, 1'b1);

    while ((m_k % FRAME) != 1) step(1'b0, 16'h0, 1'b1);
    step(1'b1, 16'h1111, 1'b1);
    idle(1, 1'b1);
    step(1'b1, 16'h2222, 1'b1);
    idle(FRAME + 4, 1'b1);
    step(1'b1, 16'h5555, 1'b1);
    while ((m_k % FRAME) != FRAME - 1) step(1'b0, 16'h0, 1'b1);
    step(1'b1, 16'h3333, 1'b1);
    idle(FRAME, 1'b1);

    step(1'b1, 16'h12AB, 1'b1);
    idle(FRAME + 5, 1'b1);
    idle(10, 1'b0);
    idle(FRAME, 1'b1);

    step(1'b1, 16'hBEEF, 1'b1);
    idle(1, 1'b1);
    pulse_reset();
    idle(3 * FRAME, 1'b1);

    for (int i = 0; i < 500; i++) begin
      v = 16'($urandom) >> (4 * $urandom_range(0, 4));
      step($urandom_range(0, 7) == 0, v, $urandom_range(0, 9) != 0);
    end
    pulse_reset();
    for (int i = 0; i < 100; i++) begin
      v = 16'($urandom);
      step($urandom_range(0, 3) == 0, v, 1'b1);
    end

    @(posedge Clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
